fpa_accumulator: RTL

FPA_ACCUMULATOR -- requirements
Module: fpa_accumulator

---
 rtl/fpa_accumulator.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fpa_accumulator.sv
// Packet floating-point accumulator that sums the beats of each packet using an external
// combinational FP adder. Optional exception flagging is enabled by defining FPA_ACC_EXC_EN.
module fpa_accumulator #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_x,
    output logic [31:0]      add_y,
    input  logic [31:0]      add_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    typedef enum logic [1:0] {StIdle, StAcc, StAdd, StDone} state_e;

    state_e           state_q;
    logic [31:0]      sum_q;
    logic [31:0]      op_q;
    logic [CNT_W-1:0] count_q;
    logic             last_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             accept;
    logic [CNT_W-1:0] count_inc;

    assign accept    = in_valid && in_ready_q;
    assign count_inc = (&count_q) ? count_q : count_q + 1'b1;

    // in_ready/out_valid are registered alongside the state so they always match it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sum_q       <= '0;
            op_q        <= '0;
            count_q     <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        sum_q   <= in_data;
                        count_q <= CNT_W'(1);
                        if (in_last) begin
                            state_q     <= StDone;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= StAcc;
                        end
                    end
                end
                StAcc: begin
                    if (accept) begin
                        op_q       <= in_data;
                        last_q     <= in_last;
                        count_q    <= count_inc;
                        state_q    <= StAdd;
                        in_ready_q <= 1'b0;
                    end
                end
                StAdd: begin
                    sum_q <= add_result;
                    if (last_q) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q    <= StAcc;
                        in_ready_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = sum_q;
    assign out_count = count_q;
    assign add_x     = sum_q;
    assign add_y     = op_q;

`ifdef FPA_ACC_EXC_EN
    logic err_q;
    logic in_exc;
    logic add_exc;

    assign in_exc  = &in_data[30:23];
    assign add_exc = &add_result[30:23];

    // Sticky per packet; the first beat in StIdle starts a fresh flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle:  if (accept) err_q <= in_exc;
                StAcc:   if (accept) err_q <= err_q | in_exc;
                StAdd:   err_q <= err_q | add_exc;
                StDone:  if (out_ready) err_q <= 1'b0;
                default: err_q <= 1'b0;
            endcase
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule
